// File: rtl/clk_ctrl_1hz.sv
// clk_ctrl_1hz: clock/timer front end.
// Turns the system clock and two raw active-low buttons into the controls the
// seconds counter uses: clk_1hz_s and tick_1hz from a programmable divider, a
// stop level from a RUN/HALT toggle FSM, and adjust_clk pulses while halted.
// Each button passes through a 2-flop synchroniser and a counter debouncer.
// Optional build macro: AUTO_REPEAT_EN adds auto-repeat of adjust_clk while
// the adjust button is held in HALT.
module clk_ctrl_1hz #(
   parameter int unsigned HALF_PERIOD   = 25000000,
   parameter int unsigned DB_CYCLES     = 1000000,
   parameter int unsigned REPEAT_DELAY  = 25000000,
   parameter int unsigned REPEAT_PERIOD = 5000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_stop_n,
   input  logic btn_adj_n,
   output logic clk_1hz_s,
   output logic tick_1hz,
   output logic stop,
   output logic adjust_clk
);

   localparam int unsigned HP_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int unsigned BTN_STOP = 0;
   localparam int unsigned BTN_ADJ  = 1;

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

   state_e          state_q, state_d;
   logic [HP_W-1:0] div_cnt_q, div_cnt_d;
   logic            clk_1hz_q, clk_1hz_d;
   logic            tick_q, tick_d;
   logic            adj_q, adj_d;

   // Per-button pipeline, index BTN_STOP / BTN_ADJ; 1 = released.
   logic [1:0]      raw;
   logic [1:0]      s1_q, s1_d;
   logic [1:0]      s2_q, s2_d;
   logic [1:0]      stable_q, stable_d;
   logic [1:0]      prev_q, prev_d;
   logic [DB_W-1:0] db_cnt_q [2];
   logic [DB_W-1:0] db_cnt_d [2];
   logic [1:0]      press;

   assign raw   = {btn_adj_n, btn_stop_n};
   assign press = ~stable_q & prev_q;

   // Synchronise and debounce both buttons; a change is accepted only after
   // DB_CYCLES consecutive edges of disagreement with the stable level.
   always_comb begin
      s1_d     = raw;
      s2_d     = s1_q;
      prev_d   = stable_q;
      stable_d = stable_q;
      for (int unsigned i = 0; i < 2; i++) begin
         db_cnt_d[i] = '0;
         if (s2_q[i] != stable_q[i]) begin
            if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
               stable_d[i] = s2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int unsigned RD_W  = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
   localparam int unsigned RP_W  = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
   localparam int unsigned REP_W = (RD_W > RP_W) ? RD_W : RP_W;

   logic             rep_on_q, rep_on_d;
   logic             rep_first_q, rep_first_d;
   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`else
   // Repeat timing is inert in this build; the parameters remain so that
   // existing overrides still elaborate.
   if ((REPEAT_DELAY == 0) && (REPEAT_PERIOD == 0)) begin : g_no_repeat
   end
`endif

   // Next-state logic: stop toggle, divider, tick and adjust pulse generation.
   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      clk_1hz_d = clk_1hz_q;
      tick_d    = 1'b0;

      if (press[BTN_STOP]) begin
         state_d = (state_q == RUN) ? HALT : RUN;
      end

      if (state_q == RUN) begin
         if (div_cnt_q == HP_W'(HALF_PERIOD - 1)) begin
            div_cnt_d = '0;
            clk_1hz_d = ~clk_1hz_q;
            tick_d    = ~clk_1hz_q;
         end else begin
            div_cnt_d = div_cnt_q + 1'b1;
         end
      end

      // Adjust is gated by the pre-toggle state.
      adj_d = press[BTN_ADJ] && (state_q == HALT);

`ifdef AUTO_REPEAT_EN
      rep_on_d    = 1'b0;
      rep_first_d = rep_first_q;
      rep_cnt_d   = '0;
      if (adj_d) begin
         rep_on_d    = 1'b1;
         rep_first_d = 1'b1;
      end else if (rep_on_q && (state_q == HALT) && !press[BTN_STOP] &&
                   !stable_q[BTN_ADJ]) begin
         rep_on_d = 1'b1;
         if (rep_first_q ? (rep_cnt_q == REP_W'(REPEAT_DELAY - 1))
                         : (rep_cnt_q == REP_W'(REPEAT_PERIOD - 1))) begin
            adj_d       = 1'b1;
            rep_first_d = 1'b0;
         end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
         end
      end
`endif
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= RUN;
         div_cnt_q   <= '0;
         clk_1hz_q   <= 1'b0;
         tick_q      <= 1'b0;
         adj_q       <= 1'b0;
         s1_q        <= '1;
         s2_q        <= '1;
         stable_q    <= '1;
         prev_q      <= '1;
         db_cnt_q[0] <= '0;
         db_cnt_q[1] <= '0;
`ifdef AUTO_REPEAT_EN
         rep_on_q    <= 1'b0;
         rep_first_q <= 1'b0;
         rep_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         clk_1hz_q   <= clk_1hz_d;
         tick_q      <= tick_d;
         adj_q       <= adj_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         stable_q    <= stable_d;
         prev_q      <= prev_d;
         db_cnt_q[0] <= db_cnt_d[0];
         db_cnt_q[1] <= db_cnt_d[1];
`ifdef AUTO_REPEAT_EN
         rep_on_q    <= rep_on_d;
         rep_first_q <= rep_first_d;
         rep_cnt_q   <= rep_cnt_d;
`endif
      end
   end

   assign clk_1hz_s  = clk_1hz_q;
   assign tick_1hz   = tick_q;
   assign stop       = (state_q == HALT);
   assign adjust_clk = adj_q;

endmodule

// File: tb/tb_clk_ctrl_1hz.sv
// Testbench for clk_ctrl_1hz: directed scenarios followed by randomized button
// activity, checked every edge against a behavioural model.
module tb_clk_ctrl_1hz;

   localparam int HP = 4;
   localparam int DB = 3;
   localparam int RD = 8;
   localparam int RP = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn_stop_n = 1'b1;
   logic btn_adj_n = 1'b1;
   logic clk_1hz_s, tick_1hz, stop, adjust_clk;

   int checks = 0;
   int errors = 0;

   clk_ctrl_1hz #(
      .HALF_PERIOD(HP),
      .DB_CYCLES(DB),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_stop_n(btn_stop_n),
      .btn_adj_n(btn_adj_n),
      .clk_1hz_s(clk_1hz_s),
      .tick_1hz(tick_1hz),
      .stop(stop),
      .adjust_clk(adjust_clk)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // Behavioural model. Divider phase is derived from the total number of
   // running edges; auto-repeat from edges elapsed since the first pulse.
   int m_run;
   bit m_halt;
   bit m_s1 [2];
   bit m_s2 [2];
   bit m_st [2];
   bit m_pv [2];
   int m_n [2];
   bit m_rep;
   int m_k;
   bit e_clk, e_tick, e_stop, e_adj;
   int tick_seen, adj_seen, adj_model;

   task automatic model_edge(input bit r, input bit bs, input bit ba);
      bit ps, pa, oh;
      bit raw [2];
      if (!r) begin
         m_run = 0; m_halt = 0; m_rep = 0; m_k = 0;
         for (int i = 0; i < 2; i++) begin
            m_s1[i] = 1; m_s2[i] = 1; m_st[i] = 1; m_pv[i] = 1; m_n[i] = 0;
         end
         e_clk = 0; e_tick = 0; e_stop = 0; e_adj = 0;
         return;
      end
      raw[0] = bs; raw[1] = ba;
      ps = !m_st[0] && m_pv[0];
      pa = !m_st[1] && m_pv[1];
      oh = m_halt;
      e_adj  = pa && oh;
      e_tick = 0;
`ifdef AUTO_REPEAT_EN
      if (pa && oh) begin
         m_rep = 1; m_k = 0;
      end else if (m_rep && oh && !ps && !m_st[1]) begin
         m_k++;
         if (m_k == RD || (m_k > RD && (m_k - RD) % RP == 0)) e_adj = 1;
      end else begin
         m_rep = 0;
      end
`endif
      if (!oh) begin
         m_run++;
         if (m_run % HP == 0 && (m_run / HP) % 2 == 1) e_tick = 1;
      end
      e_clk  = ((m_run / HP) % 2) == 1;
      m_halt = oh ^ ps;
      e_stop = m_halt;
      for (int i = 0; i < 2; i++) begin
         m_pv[i] = m_st[i];
         if (m_s2[i] != m_st[i]) begin
            m_n[i]++;
            if (m_n[i] == DB) begin
               m_st[i] = m_s2[i];
               m_n[i] = 0;
            end
         end else begin
            m_n[i] = 0;
         end
         m_s2[i] = m_s1[i];
         m_s1[i] = raw[i];
      end
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(rst, btn_stop_n, btn_adj_n);
      #1;
      chk("stop", int'(stop), int'(e_stop));
      chk("clk_1hz_s", int'(clk_1hz_s), int'(e_clk));
      chk("tick_1hz", int'(tick_1hz), int'(e_tick));
      chk("adjust_clk", int'(adjust_clk), int'(e_adj));
      if (tick_1hz === 1'b1) tick_seen++;
      if (adjust_clk === 1'b1) adj_seen++;
      if (e_adj) adj_model++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Press the stop button for 10 cycles, then release and let it settle.
   task automatic stop_press();
      btn_stop_n = 1'b0;
      steps(10);
      btn_stop_n = 1'b1;
      steps(8);
   endtask

   initial begin
      int a0, exp_pulses, n;
      bit rs, bs, ba;

      // Reset
      rst = 1'b0;
      steps(2);
      chk("reset_stop", int'(stop), 0);
      chk("reset_clk", int'(clk_1hz_s), 0);
      rst = 1'b1;

      // 1: free-running divider
      tick_seen = 0;
      steps(24);
      chk("t1_ticks", tick_seen, 3);
      chk("t1_clk_end", int'(clk_1hz_s), 0);

      // 2: short glitch on stop is rejected
      btn_stop_n = 1'b0;
      steps(2);
      btn_stop_n = 1'b1;
      steps(8);
      chk("t2_glitch_stop", int'(stop), 0);

      // 3: stop press latency, then resume
      btn_stop_n = 1'b0;
      steps(5);
      chk("t3_stop_early", int'(stop), 0);
      step();
      chk("t3_stop_edge6", int'(stop), 1);
      steps(4);
      btn_stop_n = 1'b1;
      steps(12);
      chk("t3_stop_held", int'(stop), 1);
      stop_press();
      chk("t3_resumed", int'(stop), 0);
      steps(10);

      // 4: adjust ignored in RUN, one pulse per press in HALT
      a0 = adj_seen;
      btn_adj_n = 1'b0;
      steps(10);
      btn_adj_n = 1'b1;
      steps(8);
      chk("t4_run_adj", adj_seen - a0, 0);
      stop_press();
      chk("t4_halted", int'(stop), 1);
      a0 = adj_seen;
      btn_adj_n = 1'b0;
      steps(5);
      chk("t4_adj_early", adj_seen - a0, 0);
      step();
      chk("t4_adj_edge6", int'(adjust_clk), 1);
      steps(4);
      btn_adj_n = 1'b1;
      steps(8);
`ifdef AUTO_REPEAT_EN
      exp_pulses = 2;
`else
      exp_pulses = 1;
`endif
      chk("t4_adj_count", adj_seen - a0, exp_pulses);

      // 6: long hold in HALT (auto-repeat when enabled)
      a0 = adj_seen;
      btn_adj_n = 1'b0;
      steps(31);
      btn_adj_n = 1'b1;
      steps(12);
`ifdef AUTO_REPEAT_EN
      exp_pulses = 7;
`else
      exp_pulses = 1;
`endif
      chk("t6_adj_count", adj_seen - a0, exp_pulses);

      // 5: reset while halted with stop held; requalification afterwards
      stop_press();
      n = 0;
      while (clk_1hz_s !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("t5_reach_clk1", int'(clk_1hz_s), 1);
      btn_stop_n = 1'b0;
      steps(6);
      chk("t5_halted", int'(stop), 1);
      rst = 1'b0;
      step();
      chk("t5_rst_stop", int'(stop), 0);
      chk("t5_rst_clk", int'(clk_1hz_s), 0);
      chk("t5_rst_tick", int'(tick_1hz), 0);
      chk("t5_rst_adj", int'(adjust_clk), 0);
      rst = 1'b1;
      steps(5);
      chk("t5_requal_early", int'(stop), 0);
      step();
      chk("t5_requal_edge6", int'(stop), 1);
      btn_stop_n = 1'b1;
      steps(8);

      // Randomized button activity with occasional reset
      adj_seen = 0;
      adj_model = 0;
      for (int seg = 0; seg < 200; seg++) begin
         rs = ($urandom_range(0, 39) != 0);
         bs = ($urandom_range(0, 2) != 0);
         ba = ($urandom_range(0, 1) != 0);
         rst = rs;
         btn_stop_n = bs;
         btn_adj_n = ba;
         steps(rs ? $urandom_range(1, 14) : 1);
      end
      rst = 1'b1;
      btn_stop_n = 1'b1;
      btn_adj_n = 1'b1;
      steps(10);
      chk("rand_adj_total", adj_seen, adj_model);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
